// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver (in: clk, reset, rx; out: rx_data byte, rx_data_ready pulse, frame_error pulse)
module uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_data_ready,
  output logic       frame_error
);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t state, state_n;
  logic rx_m, rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n, data_n;
  logic ready_n, ferr_n;
  logic half_end, bit_end;
  assign half_end = cnt == CW'(HALF_BIT - 1);
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    shift_n = shift;
    data_n = rx_data;
    ready_n = 1'b0;
    ferr_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        state_n = rx_s ? IDLE : START;
      end
      START: if (half_end) begin
        cnt_n = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (bit_end) begin
        cnt_n = '0;
        shift_n[idx] = rx_s;
        idx_n = idx + 3'd1;
        state_n = (idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (bit_end) begin
        cnt_n = '0;
        data_n = rx_s ? shift : rx_data;
        ready_n = rx_s;
        ferr_n = !rx_s;
        state_n = rx_s ? IDLE : BREAK;
      end
      BREAK: begin
        cnt_n = '0;
        state_n = rx_s ? IDLE : BREAK;
      end
      default: begin
        cnt_n = '0;
        idx_n = '0;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      rx_data <= '0;
      rx_data_ready <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      rx_data <= data_n;
      rx_data_ready <= ready_n;
      frame_error <= ferr_n;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at 16 clocks per bit
module tb_uart_rx;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic [7:0] rx_data;
  logic rx_data_ready, frame_error;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int overlap = 0;
  logic [7:0] rq[$];
  int rc[$];
  int fc[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .rx_data(rx_data),
    .rx_data_ready(rx_data_ready),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rx_data_ready) begin
      rq.push_back(rx_data);
      rc.push_back(cyc);
    end
    if (frame_error) fc.push_back(cyc);
    if (rx_data_ready && frame_error) overlap++;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    rq.delete();
    rc.delete();
    fc.delete();
  endtask

  task automatic send(input logic [7:0] b, input logic stop, output int t0);
    rx = 1'b0;
    t0 = cyc;
    wait_n(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_n(CPB);
    end
    rx = stop;
    wait_n(CPB);
  endtask

  task automatic expect_one(input string name, input logic [7:0] v, input int t0);
    tests++;
    if (rq.size() !== 1) begin
      fails++;
      $display("FAIL %s_count: got %0d ready pulses, expected 1", name, rq.size());
    end else begin
      tests++;
      if (rq[0] !== v) begin
        fails++;
        $display("FAIL %s_value: got %02h, expected %02h", name, rq[0], v);
      end
      tests++;
      if (rc[0] !== t0 + 155) begin
        fails++;
        $display("FAIL %s_latency: got cycle %0d, expected %0d", name, rc[0], t0 + 155);
      end
    end
    tests++;
    if (fc.size() !== 0) begin
      fails++;
      $display("FAIL %s_ferr: got %0d frame_error pulses, expected 0", name, fc.size());
    end
    tests++;
    if (rx_data !== v) begin
      fails++;
      $display("FAIL %s_hold: rx_data got %02h, expected %02h", name, rx_data, v);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_n(3);
    tests++;
    if ({rx_data, rx_data_ready, frame_error} !== 10'h000) begin
      fails++;
      $display("FAIL reset_outputs: got %03h, expected 000", {rx_data, rx_data_ready, frame_error});
    end
    reset = 1'b0;
    wait_n(5);
  endtask

  task automatic test_single();
    int t0;
    clear_log();
    send(8'h41, 1'b1, t0);
    wait_n(10);
    expect_one("single_41", 8'h41, t0);
  endtask

  task automatic test_back_to_back();
    int t0, t1, t2;
    logic [7:0] exp_v[3];
    exp_v = '{8'h00, 8'hFF, 8'hA5};
    clear_log();
    send(8'h00, 1'b1, t0);
    send(8'hFF, 1'b1, t1);
    send(8'hA5, 1'b1, t2);
    wait_n(10);
    tests++;
    if (rq.size() !== 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d ready pulses, expected 3", rq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (rq[i] !== exp_v[i]) begin
          fails++;
          $display("FAIL b2b_value%0d: got %02h, expected %02h", i, rq[i], exp_v[i]);
        end
      end
      tests++;
      if (rc[0] !== t0 + 155) begin
        fails++;
        $display("FAIL b2b_latency: got cycle %0d, expected %0d", rc[0], t0 + 155);
      end
      for (int i = 1; i < 3; i++) begin
        tests++;
        if (rc[i] - rc[i-1] !== 160) begin
          fails++;
          $display("FAIL b2b_spacing%0d: got %0d cycles, expected 160", i, rc[i] - rc[i-1]);
        end
      end
    end
    tests++;
    if (fc.size() !== 0) begin
      fails++;
      $display("FAIL b2b_ferr: got %0d frame_error pulses, expected 0", fc.size());
    end
  endtask

  task automatic test_glitch();
    int t0;
    clear_log();
    rx = 1'b0;
    wait_n(4);
    rx = 1'b1;
    wait_n(40);
    tests++;
    if (rq.size() + fc.size() !== 0) begin
      fails++;
      $display("FAIL glitch_pulses: got %0d pulses, expected 0", rq.size() + fc.size());
    end
    send(8'h3C, 1'b1, t0);
    wait_n(10);
    expect_one("glitch_3c", 8'h3C, t0);
  endtask

  task automatic test_frame_error();
    int t0;
    clear_log();
    send(8'h55, 1'b0, t0);
    wait_n(200);
    tests++;
    if (fc.size() !== 1) begin
      fails++;
      $display("FAIL ferr_count: got %0d frame_error pulses, expected 1", fc.size());
    end else begin
      tests++;
      if (fc[0] !== t0 + 155) begin
        fails++;
        $display("FAIL ferr_latency: got cycle %0d, expected %0d", fc[0], t0 + 155);
      end
    end
    tests++;
    if (rq.size() !== 0) begin
      fails++;
      $display("FAIL ferr_ready: got %0d ready pulses, expected 0", rq.size());
    end
    tests++;
    if (rx_data !== 8'h3C) begin
      fails++;
      $display("FAIL ferr_hold: rx_data got %02h, expected 3c", rx_data);
    end
    rx = 1'b1;
    wait_n(20);
    clear_log();
    send(8'h12, 1'b1, t0);
    wait_n(10);
    expect_one("after_break_12", 8'h12, t0);
  endtask

  task automatic test_reset_mid();
    int t0;
    logic [7:0] b;
    b = 8'hF0;
    clear_log();
    rx = 1'b0;
    wait_n(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_n(CPB);
    end
    rx = b[4];
    wait_n(CPB / 2);
    reset = 1'b1;
    wait_n(1);
    tests++;
    if ({rx_data, rx_data_ready, frame_error} !== 10'h000) begin
      fails++;
      $display("FAIL midreset_outputs: got %03h, expected 000", {rx_data, rx_data_ready, frame_error});
    end
    rx = 1'b1;
    wait_n(4);
    reset = 1'b0;
    wait_n(200);
    tests++;
    if (rq.size() + fc.size() !== 0) begin
      fails++;
      $display("FAIL midreset_pulses: got %0d pulses, expected 0", rq.size() + fc.size());
    end
    send(8'hC3, 1'b1, t0);
    wait_n(10);
    expect_one("after_reset_c3", 8'hC3, t0);
  endtask

  task automatic test_exclusive();
    tests++;
    if (overlap !== 0) begin
      fails++;
      $display("FAIL exclusive: got %0d cycles with both pulses high, expected 0", overlap);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
